// File: rtl/huffman_decoder.sv
// Serial MSB-first Huffman decoder for a six-symbol table of right-aligned codes
// with thermometer length masks; emits one symbol index per completed codeword.
module huffman_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       sym_valid,
    output logic [7:0] sym_data,
    output logic       err,
    output logic [7:0] sym_cnt,
    output logic       busy
);

    typedef enum logic [1:0] {ST_EMPTY, ST_RUN, ST_ERR} state_t;

    state_t     state_reg, state_next;

    logic [7:0] hc_in [6];
    logic [7:0] m_in  [6];
    logic [7:0] hc_reg [6];
    logic [7:0] m_reg  [6];
    logic [3:0] maxlen_reg;
    logic [7:0] m_or;
    logic [3:0] maxlen_in;

    logic [7:0] sh_reg, sh_next;
    logic [3:0] len_reg, len_next;
    logic       sym_valid_reg, sym_valid_next;
    logic [7:0] sym_data_reg, sym_data_next;
    logic       err_reg, err_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       busy_reg;

    logic       bit_take;
    logic [7:0] nsh;
    logic [3:0] nlen;
    logic [7:0] therm;
    logic [5:0] match;
    logic       any_match;
    logic [2:0] hit_idx;
    logic       out_of_bits;

    assign hc_in[0] = HC1;
    assign hc_in[1] = HC2;
    assign hc_in[2] = HC3;
    assign hc_in[3] = HC4;
    assign hc_in[4] = HC5;
    assign hc_in[5] = HC6;
    assign m_in[0]  = M1;
    assign m_in[1]  = M2;
    assign m_in[2]  = M3;
    assign m_in[3]  = M4;
    assign m_in[4]  = M5;
    assign m_in[5]  = M6;

    // The longest code length is the width of the union of all masks.
    always_comb begin
        m_or = 8'h00;
        for (int i = 0; i < 6; i++) begin
            m_or = m_or | m_in[i];
        end
        maxlen_in = 4'($countones(m_or));
    end

    // A bit is consumed only while decoding; a simultaneous load drops it.
    assign bit_take    = (state_reg == ST_RUN) && bit_valid && !code_valid;
    assign nsh         = {sh_reg[6:0], bit_in};
    assign nlen        = len_reg + 4'd1;
    assign therm       = ~(8'hFF << nlen);
    assign out_of_bits = (nlen >= maxlen_reg);

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_match
            assign match[gi] = (m_reg[gi] == therm) && ((nsh & m_reg[gi]) == hc_reg[gi]);
        end
    endgenerate

    // Lowest index wins when a malformed table yields several matches.
    always_comb begin
        any_match = |match;
        hit_idx   = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (code_valid) begin
            state_next = ST_RUN;
        end else if (bit_take && !any_match && out_of_bits) begin
            state_next = ST_ERR;
        end
    end

    always_comb begin
        sh_next        = sh_reg;
        len_next       = len_reg;
        sym_valid_next = 1'b0;
        sym_data_next  = sym_data_reg;
        err_next       = 1'b0;
        cnt_next       = cnt_reg;
        if (code_valid) begin
            sh_next  = 8'h00;
            len_next = 4'd0;
            cnt_next = 8'h00;
        end else if (bit_take) begin
            if (any_match) begin
                sym_valid_next = 1'b1;
                sym_data_next  = 8'(hit_idx) + 8'd1;
                cnt_next       = cnt_reg + 8'd1;
                sh_next        = 8'h00;
                len_next       = 4'd0;
            end else if (out_of_bits) begin
                err_next = 1'b1;
                sh_next  = 8'h00;
                len_next = 4'd0;
            end else begin
                sh_next  = nsh;
                len_next = nlen;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_reg        <= 8'h00;
            len_reg       <= 4'd0;
            sym_valid_reg <= 1'b0;
            sym_data_reg  <= 8'h00;
            err_reg       <= 1'b0;
            cnt_reg       <= 8'h00;
            busy_reg      <= 1'b0;
        end else begin
            sh_reg        <= sh_next;
            len_reg       <= len_next;
            sym_valid_reg <= sym_valid_next;
            sym_data_reg  <= sym_data_next;
            err_reg       <= err_next;
            cnt_reg       <= cnt_next;
            busy_reg      <= (len_next != 4'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            maxlen_reg <= 4'd0;
            for (int i = 0; i < 6; i++) begin
                hc_reg[i] <= 8'h00;
                m_reg[i]  <= 8'h00;
            end
        end else if (code_valid) begin
            maxlen_reg <= maxlen_in;
            for (int i = 0; i < 6; i++) begin
                hc_reg[i] <= hc_in[i];
                m_reg[i]  <= m_in[i];
            end
        end
    end

    assign sym_valid = sym_valid_reg;
    assign sym_data  = sym_data_reg;
    assign err       = err_reg;
    assign sym_cnt   = cnt_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed scenarios with literal expectations plus
// randomized streams checked every cycle against a codeword-lookup model.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       code_valid = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic [7:0] hc_a [6];
    logic [7:0] m_a  [6];
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       err;
    logic [7:0] sym_cnt;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    huffman_decoder dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(hc_a[0]), .HC2(hc_a[1]), .HC3(hc_a[2]),
        .HC4(hc_a[3]), .HC5(hc_a[4]), .HC6(hc_a[5]),
        .M1(m_a[0]), .M2(m_a[1]), .M3(m_a[2]),
        .M4(m_a[3]), .M5(m_a[4]), .M6(m_a[5]),
        .bit_valid(bit_valid), .bit_in(bit_in),
        .sym_valid(sym_valid), .sym_data(sym_data), .err(err),
        .sym_cnt(sym_cnt), .busy(busy)
    );

    // Model: the table as (length, value) pairs; the bits received since the
    // last codeword boundary are looked up by exact length and value.
    localparam logic [1:0] MD_EMPTY = 2'd0, MD_RUN = 2'd1, MD_ERR = 2'd2;
    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] acc;
        logic [3:0] n;
        logic       sv;
        logic [7:0] sd;
        logic       er;
        logic [7:0] cnt;
    } mdl_t;

    mdl_t exp_s;
    int   drv_len [6];
    int   drv_val [6];
    int   ld_len  [6];
    int   ld_val  [6];
    int   seen [$];
    int   err_seen = 0;

    function automatic mdl_t model_next(mdl_t s, logic cv, logic bv, logic b);
        mdl_t r;
        int   mx;
        int   hit;
        r    = s;
        r.sv = 1'b0;
        r.er = 1'b0;
        if (cv) begin
            r.mode = MD_RUN;
            r.acc  = 8'h00;
            r.n    = 4'd0;
            r.cnt  = 8'h00;
        end else if (bv && s.mode == MD_RUN) begin
            r.acc = {s.acc[6:0], b};
            r.n   = s.n + 4'd1;
            mx    = 0;
            hit   = 0;
            for (int i = 0; i < 6; i++) begin
                if (ld_len[i] > mx) mx = ld_len[i];
                if (hit == 0 && ld_len[i] == int'(r.n) && ld_val[i] == int'(r.acc)) hit = i + 1;
            end
            if (hit != 0) begin
                r.sv  = 1'b1;
                r.sd  = 8'(hit);
                r.cnt = s.cnt + 8'd1;
                r.acc = 8'h00;
                r.n   = 4'd0;
            end else if (int'(r.n) >= mx) begin
                r.er   = 1'b1;
                r.mode = MD_ERR;
                r.acc  = 8'h00;
                r.n    = 4'd0;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_s <= '0;
            for (int i = 0; i < 6; i++) begin
                ld_len[i] <= 0;
                ld_val[i] <= 0;
            end
        end else begin
            exp_s <= model_next(exp_s, code_valid, bit_valid, bit_in);
            if (code_valid) begin
                for (int i = 0; i < 6; i++) begin
                    ld_len[i] <= drv_len[i];
                    ld_val[i] <= drv_val[i];
                end
            end
        end
    end

    task automatic chk(string nm, int act, int expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        chk("sym_valid", int'(sym_valid), int'(exp_s.sv));
        chk("err", int'(err), int'(exp_s.er));
        chk("sym_cnt", int'(sym_cnt), int'(exp_s.cnt));
        chk("busy", int'(busy), int'(exp_s.n != 4'd0));
        chk("sym_data", int'(sym_data), int'(exp_s.sd));
        if (sym_valid) seen.push_back(int'(sym_data));
        if (err) err_seen++;
    end

    task automatic chk_seq(string nm, int want[$]);
        chk({nm, "_count"}, seen.size(), want.size());
        for (int i = 0; i < want.size() && i < seen.size(); i++) begin
            chk(nm, seen[i], want[i]);
        end
    endtask

    task automatic drive(logic cv, logic bv, logic b);
        @(posedge clk);
        #2;
        code_valid = cv;
        bit_valid  = bv;
        bit_in     = b;
    endtask

    task automatic send(string s);
        for (int i = 0; i < s.len(); i++) drive(1'b0, 1'b1, s[i] == 8'h31);
    endtask

    task automatic settle();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
    endtask

    task automatic set_tbl(int tl[6], int tv[6]);
        for (int i = 0; i < 6; i++) begin
            drv_len[i] = tl[i];
            drv_val[i] = tv[i];
            hc_a[i]    = 8'(tv[i]);
            m_a[i]     = (tl[i] == 0) ? 8'h00 : ~(8'hFF << tl[i]);
        end
    endtask

    task automatic load_t(int dis);
        int tl[6] = '{1, 2, 3, 4, 5, 5};
        int tv[6] = '{1, 0, 3, 5, 8, 9};
        if (dis >= 0) tl[dis] = 0;
        set_tbl(tl, tv);
        drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    initial begin
        int tl[6];
        int tv[6];
        int bl[6] = '{1, 2, 3, 4, 5, 5};
        int bv[6] = '{1, 0, 3, 5, 8, 9};
        load_t(-1);
        code_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_sym_valid", int'(sym_valid), 0);
        chk("rst_sym_data", int'(sym_data), 0);
        chk("rst_busy", int'(busy), 0);

        // EMPTY ignores bits
        send("1");
        settle();
        chk("empty_ignored", seen.size(), 0);

        // 1: all six codewords back to back
        load_t(-1);
        send("10001101010100001001");
        settle();
        chk_seq("t1_seq", {1, 2, 3, 4, 5, 6});
        chk("t1_cnt", int'(sym_cnt), 6);
        chk("t1_err", err_seen, 0);

        // 2: consecutive 1-bit codes, then gaps inside "0101"
        seen.delete();
        load_t(-1);
        send("11111111");
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 chk("t2_busy_gap", int'(busy), 1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        settle();
        chk_seq("t2_seq", {1, 1, 1, 1, 1, 1, 1, 1, 4});

        // 3: symbol 6 unused -> error at maximum length, then ignored until reload
        seen.delete();
        err_seen = 0;
        load_t(5);
        send("01001");
        settle();
        chk("t3_err", err_seen, 1);
        send("1");
        settle();
        chk("t3_ignored", seen.size(), 0);
        load_t(-1);
        send("1");
        settle();
        chk_seq("t3_seq", {1});

        // 4: load together with a bit mid-codeword
        seen.delete();
        load_t(-1);
        send("01");
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("t4_busy", int'(busy), 0);
        chk("t4_cnt", int'(sym_cnt), 0);
        send("00");
        settle();
        chk_seq("t4_seq", {2});

        // 5: asynchronous reset mid-codeword
        seen.delete();
        load_t(-1);
        send("101");
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 chk("t5_busy_pre", int'(busy), 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("t5_cnt_rst", int'(sym_cnt), 0);
        chk("t5_busy_rst", int'(busy), 0);
        chk("t5_data_rst", int'(sym_data), 0);
        @(posedge clk);
        #3 reset = 1'b1;
        seen.delete();
        send("1100");
        settle();
        chk("t5_no_sym", seen.size(), 0);

        // 6: counter wrap
        seen.delete();
        load_t(-1);
        for (int i = 0; i < 255; i++) drive(1'b0, 1'b1, 1'b1);
        settle();
        chk("t6_cnt255", int'(sym_cnt), 255);
        send("1");
        settle();
        chk("t6_wrap", int'(sym_cnt), 0);
        chk("t6_pulses", seen.size(), 256);

        // Randomized: shuffled code assignments, disabled symbols, reloads, resets
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 6; i++) begin
                tl[i] = bl[i];
                tv[i] = bv[i];
            end
            for (int i = 5; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(0, i);
                t = tl[i]; tl[i] = tl[j]; tl[j] = t;
                t = tv[i]; tv[i] = tv[j]; tv[j] = t;
            end
            if ($urandom_range(0, 2) == 0) tl[$urandom_range(0, 5)] = 0;
            if ($urandom_range(0, 9) == 0) for (int i = 0; i < 6; i++) tl[i] = 0;
            set_tbl(tl, tv);
            drive(1'b1, 1'b0, 1'b0);
            for (int c = 0; c < 60; c++) begin
                int p;
                p = $urandom_range(0, 99);
                if (p < 2) pulse_reset();
                else if (p < 6) drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                else drive(1'b0, p < 80, 1'($urandom_range(0, 1)));
            end
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Serial Huffman decoder: the receiving end of the Huffman code-table generator. It captures the six-symbol code table (HC1..HC6, M1..M6) on `code_valid`. It then consumes an MSB-first serial bitstream, one bit per valid cycle, and emits one decoded symbol index (1..6) per completed codeword. It also flags bit sequences that match no codeword.

## Interface
- No parameters. Symbol count is fixed at 6 and code width at 8.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; `reset`=0 clears all state.
- `code_valid` in 1: one-cycle strobe; load HC1..HC6 and M1..M6 this cycle.
- `HC1`..`HC6` in 8 each: codeword value, right-aligned; the MSB of the valid field is the first transmitted bit.
- `M1`..`M6` in 8 each: right-aligned thermometer length mask (8'h07 = 3 bits). 8'h00 = symbol unused, never matches.
- `bit_valid` in 1: `bit_in` is valid this cycle. No backpressure; the block is always able to accept.
- `bit_in` in 1: serial code bit.
- `sym_valid` out 1: registered one-cycle pulse; `sym_data` holds a decoded symbol.
- `sym_data` out 8: decoded symbol index 1..6; holds its last value between pulses.
- `err` out 1: registered one-cycle pulse; no codeword matched at the maximum table length.
- `sym_cnt` out 8: decoded-symbol counter; wraps 255→0.
- `busy` out 1: registered; high while a partial codeword is held (len≠0).

## Operation
- States:
  - EMPTY (after reset): bits ignored.
  - RUN: decoding.
  - ERR: bits ignored until the next `code_valid`.
- Transitions:
  - `code_valid` from any state → RUN. Loads table, clears shift register `sh` and length `len`, clears `sym_cnt`.
  - RUN → ERR on an `err` pulse.
- Load: store all 12 inputs. Also store `maxlen` = popcount(M1|M2|...|M6), range 0..8.
- RUN, per `bit_valid` cycle:
  - `nsh` = {sh[6:0], bit_in}, `nlen` = len+1, `therm` = (1<<nlen)-1.
  - Symbol i matches when M_i == therm and (nsh & M_i) == HC_i.
  - Match: `sym_valid`=1, `sym_data`=i, `sym_cnt`+1, then sh and len are cleared. If several symbols match (malformed table), the lowest index wins.
  - No match and nlen ≥ maxlen: `err`=1, go to ERR, clear sh and len. With maxlen=0, the first bit errors.
  - Otherwise: sh←nsh, len←nlen.
- `bit_valid`=0: no state change, no pulses.
- `code_valid` and `bit_valid` in the same cycle: load wins, the bit is dropped, no pulses.
- `bit_valid` in EMPTY or ERR: ignored.
- `len` never exceeds 8, because maxlen ≤ 8 forces a match or an error by the 8th bit.

## Timing
- Reset values:
  - Outputs: `sym_valid`=0, `sym_data`=0, `err`=0, `sym_cnt`=0, `busy`=0.
  - Internal: sh=0, len=0, state=EMPTY, table=0.
- Latency: the bit sampled at edge k completes a codeword → `sym_valid` and `sym_data` are high in the cycle after edge k (1 cycle). `err` has the same latency.
- Back-to-back codewords: the first bit of the next codeword can arrive in the cycle immediately after the last bit of the previous one. Consecutive 1-bit codewords give consecutive `sym_valid` cycles.
- `sym_cnt` and `busy` update on the same edge as `sym_valid`.
- First decodable bit: the cycle after `code_valid`.
- Reset asserted mid-codeword: everything clears immediately; `code_valid` is required before decoding resumes.

## Test plan
All tests use table T unless stated:
- Codes: 1:"1", 2:"00", 3:"011", 4:"0101", 5:"01000", 6:"01001".
- Values: HC=01,00,03,05,08,09; M=01,03,07,0F,1F,1F (hex).

1. Load T, stream 1 00 011 0101 01000 01001 with continuous `bit_valid` → `sym_data` pulses 1,2,3,4,5,6, each the cycle after the codeword's last bit; `sym_cnt`=6; `err` never high.
2. Load T, stream "1" eight times, then gaps of `bit_valid`=0 inside "0101" → 8 consecutive pulses of 1, then one pulse of 4; no pulses during gaps; `busy` high across the gaps.
3. Load T with M6=00. Stream 01001 → `err` pulse after bit 5, `sym_valid` stays 0. Subsequent bits are ignored until reload; reload T, stream "1" → symbol 1.
4. Mid-codeword, after "01": `code_valid` together with `bit_valid` → bit dropped, `busy`=0, `sym_cnt`=0. Stream "00" → symbol 2.
5. Mid-codeword: drive `reset`=0 → all outputs 0 immediately. Release reset and stream bits with no load → no pulses.
6. Decode 256 "1"s → `sym_cnt` wraps to 0 on the 256th pulse.
